// File: rtl/pkt_fifo_pkg.sv
// Shared types and constants for the commit/rollback packet FIFO.
//   wr_state_e : write-side FSM states
//   entry_w()  : width of one RAM entry ({last, data}) for a given data width
//   DROP_CNT_W : width of the saturating drop counter
package pkt_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,     // between packets, nothing uncommitted
        IN_PKT,   // at least one speculative word written
        DISCARD   // overflowed packet, swallowing words until its last
    } wr_state_e;

    localparam int unsigned DROP_CNT_W = 16;

    // A packed struct cannot take a parameter inside a package, so the top
    // declares entry_t locally from its W_EL and this helper sizes the RAM.
    function automatic int unsigned entry_w(input int unsigned w_el);
        return w_el + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output that only updates when re is high. No reset, so it can map onto
// a block RAM.
//   clk              clock
//   we/waddr/wdata   write port
//   re/raddr         read request; rd_data valid the cycle after re
//   rd_data          registered read data (holds while re is low)
module sdp_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array and read register carry no reset; a reset would stop
    // the tools from placing this in block RAM, and the top never exposes
    // stale contents because rvalid gates the output.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rd_data_q <= mem[raddr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pkt_fifo_commit.sv
// Packet FIFO with speculative writes, commit on last word and rollback on
// drop/overflow. First-word-fall-through read side built on a registered
// RAM read.
//   clk, reset            clock, synchronous active-high reset
//   wen/wdata/wlast/wdrop write word, end-of-packet commit, discard packet
//   full/afull            no free entry / free entries <= AFULL_THRESH
//   ren                   pop head word (ignored unless rvalid)
//   rvalid/rdata/rlast    head word of committed data
//   pkt_count             committed packets not yet fully popped
//   drop_count            discarded packets, saturating
module pkt_fifo_commit
    import pkt_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned W_EL         = 8,
    parameter int unsigned AFULL_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wen,
    input  logic [W_EL-1:0]       wdata,
    input  logic                  wlast,
    input  logic                  wdrop,
    output logic                  full,
    output logic                  afull,
    input  logic                  ren,
    output logic                  rvalid,
    output logic [W_EL-1:0]       rdata,
    output logic                  rlast,
    output logic [ADDR_WIDTH:0]   pkt_count,
    output logic [DROP_CNT_W-1:0] drop_count
);

    typedef struct packed {
        logic            last;
        logic [W_EL-1:0] data;
    } entry_t;

    localparam int unsigned        ENTRY_W = entry_w(W_EL);
    localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);

    wr_state_e state_q, state_d;

    // Pointers carry one wrap bit above the address so full and empty differ.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   cptr_q, cptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   pkt_count_q, pkt_count_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  rvalid_q, rvalid_d;

    logic                  ram_we;
    logic                  commit;
    logic                  drop_evt;
    logic                  pop;
    logic                  pop_last;
    logic                  load;
    logic [ADDR_WIDTH:0]   fetch_ptr;
    logic [ADDR_WIDTH:0]   occ_d;
    logic [ADDR_WIDTH:0]   free_d;
    logic [ENTRY_W-1:0]    ram_rdata;
    entry_t                ram_wentry;
    entry_t                ram_rentry;

    assign ram_wentry = '{last: wlast, data: wdata};
    assign ram_rentry = ram_rdata;

    // Write FSM: speculative write pointer, commit pointer, drop events.
    // full_q is registered, so a same-cycle pop never makes room for a write.
    // NOTE: every signal gets a default before the case; a path that skipped
    // one would infer a latch.
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        cptr_d   = cptr_q;
        ram_we   = 1'b0;
        commit   = 1'b0;
        drop_evt = 1'b0;

        case (state_q)
            IDLE, IN_PKT: begin
                if (state_q == IN_PKT && wdrop) begin
                    wptr_d   = cptr_q;
                    drop_evt = 1'b1;
                    state_d  = IDLE;
                end else if (wen && !wdrop) begin
                    if (full_q) begin
                        wptr_d   = cptr_q;
                        drop_evt = 1'b1;
                        state_d  = wlast ? IDLE : DISCARD;
                    end else begin
                        ram_we  = 1'b1;
                        wptr_d  = wptr_q + ONE;
                        commit  = wlast;
                        state_d = wlast ? IDLE : IN_PKT;
                    end
                end
            end
            DISCARD: begin
                if (wdrop || (wen && wlast)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            cptr_d = wptr_q + ONE;
        end
    end

    // FWFT read side. rptr addresses the word held in the RAM output
    // register while rvalid is high; the next fetch is the word after it.
    // A fetch is issued whenever the output slot is empty or being popped
    // and a committed word is available, giving one word per cycle.
    always_comb begin
        pop       = ren && rvalid_q;
        pop_last  = pop && ram_rentry.last;
        fetch_ptr = rvalid_q ? (rptr_q + ONE) : rptr_q;
        load      = (!rvalid_q || pop) && (fetch_ptr != cptr_q);
        rptr_d    = pop ? (rptr_q + ONE) : rptr_q;
        rvalid_d  = load || (rvalid_q && !pop);

        pkt_count_d = pkt_count_q;
        case ({commit, pop_last})
            2'b10:   pkt_count_d = pkt_count_q + ONE;
            2'b01:   pkt_count_d = pkt_count_q - ONE;
            default: pkt_count_d = pkt_count_q;
        endcase

        drop_count_d = drop_count_q;
        if (drop_evt && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_CNT_W'(1);
        end

        // Flags are computed from next-state pointers so they are registered
        // and reflect pops and rollbacks one cycle later.
        occ_d   = wptr_d - rptr_d;
        free_d  = DEPTH - occ_d;
        full_d  = (occ_d == DEPTH);
        afull_d = (32'(free_d) <= AFULL_THRESH);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            cptr_q       <= '0;
            rptr_q       <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            full_q       <= 1'b0;
            afull_q      <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cptr_q       <= cptr_d;
            rptr_q       <= rptr_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            full_q       <= full_d;
            afull_q      <= afull_d;
            rvalid_q     <= rvalid_d;
        end
    end

    sdp_ram #(
        .ADDR_W (ADDR_WIDTH),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (wptr_q[ADDR_WIDTH-1:0]),
        .wdata   (ram_wentry),
        .re      (load),
        .raddr   (fetch_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    // The RAM output register is not reset; gate it so idle outputs read 0.
    assign rdata      = rvalid_q ? ram_rentry.data : '0;
    assign rlast      = rvalid_q && ram_rentry.last;
    assign rvalid     = rvalid_q;
    assign full       = full_q;
    assign afull      = afull_q;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_pkt_fifo_commit.sv
// Self-checking bench for pkt_fifo_commit (depth 16, 8-bit words).
// A queue-based reference model tracks committed words with their commit
// cycle, the uncommitted packet, and the discard condition; it predicts
// every output each cycle.
module tb_pkt_fifo_commit;

    localparam int AW    = 4;
    localparam int W     = 8;
    localparam int TH    = 4;
    localparam int DEPTH = 16;

    logic         clk;
    logic         reset;
    logic         wen;
    logic [W-1:0] wdata;
    logic         wlast;
    logic         wdrop;
    logic         full;
    logic         afull;
    logic         ren;
    logic         rvalid;
    logic [W-1:0] rdata;
    logic         rlast;
    logic [AW:0]  pkt_count;
    logic [15:0]  drop_count;

    pkt_fifo_commit #(
        .ADDR_WIDTH   (AW),
        .W_EL         (W),
        .AFULL_THRESH (TH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wen        (wen),
        .wdata      (wdata),
        .wlast      (wlast),
        .wdrop      (wdrop),
        .full       (full),
        .afull      (afull),
        .ren        (ren),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rlast      (rlast),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic         last;
        logic [W-1:0] data;
        int           cyc;
    } went_t;

    went_t       cq[$];     // committed, not yet popped (head first)
    went_t       pend[$];   // uncommitted words of the current packet
    bit          discarding = 1'b0;
    int unsigned drops      = 0;
    int          cyc        = 0;
    bit          model_on   = 1'b0;

    logic         e_rvalid, e_rlast, e_full, e_afull;
    logic [W-1:0] e_rdata;
    int           e_pkt;

    function automatic void calc_exp();
        int occ;
        occ      = cq.size() + pend.size();
        e_full   = (occ == DEPTH);
        e_afull  = ((DEPTH - occ) <= TH);
        // A word is readable two cycles after the cycle it was committed in.
        e_rvalid = (cq.size() > 0) && (cq[0].cyc <= cyc - 2);
        e_rdata  = e_rvalid ? cq[0].data : '0;
        e_rlast  = e_rvalid ? cq[0].last : 1'b0;
        e_pkt    = 0;
        foreach (cq[i]) if (cq[i].last) e_pkt++;
    endfunction

    function automatic void bump_drops();
        if (drops < 32'hFFFF) drops++;
    endfunction

    function automatic void model_apply(input logic r, input logic we, input logic [W-1:0] d,
                                        input logic wl, input logic wd, input logic re);
        calc_exp();
        if (r) begin
            cq.delete();
            pend.delete();
            discarding = 1'b0;
            drops      = 0;
        end else begin
            if (re && e_rvalid) void'(cq.pop_front());
            if (discarding) begin
                if (wd || (we && wl)) discarding = 1'b0;
            end else if (wd) begin
                if (pend.size() > 0) begin
                    pend.delete();
                    bump_drops();
                end
            end else if (we) begin
                if (e_full) begin
                    pend.delete();
                    bump_drops();
                    discarding = !wl;
                end else begin
                    pend.push_back('{last: wl, data: d, cyc: 0});
                    if (wl) begin
                        foreach (pend[i]) begin
                            pend[i].cyc = cyc;
                            cq.push_back(pend[i]);
                        end
                        pend.delete();
                    end
                end
            end
        end
        cyc++;
    endfunction

    task automatic compare_model();
        calc_exp();
        check("m_rvalid", 32'(rvalid), 32'(e_rvalid));
        check("m_rdata", 32'(rdata), 32'(e_rdata));
        check("m_rlast", 32'(rlast), 32'(e_rlast));
        check("m_full", 32'(full), 32'(e_full));
        check("m_afull", 32'(afull), 32'(e_afull));
        check("m_pkt_count", 32'(pkt_count), 32'(e_pkt));
        check("m_drop_count", 32'(drop_count), drops);
    endtask

    // One clock cycle: called just after a rising edge. Compare outputs,
    // drive this cycle's inputs, advance the model, move past the next edge.
    task automatic step(input logic r, input logic we, input logic [W-1:0] d,
                        input logic wl, input logic wd, input logic re);
        if (model_on) compare_model();
        reset = r; wen = we; wdata = d; wlast = wl; wdrop = wd; ren = re;
        model_apply(r, we, d, wl, wd, re);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] d, input logic l, input logic re = 1'b0);
        step(1'b0, 1'b1, d, l, 1'b0, re);
    endtask

    task automatic idle(input int n, input logic re = 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, re);
    endtask

    // ---------------- directed table ----------------
    // Each row: inputs for one cycle, and the outputs expected at the start
    // of that cycle (i.e. the result of the preceding rows).
    typedef struct {
        logic         r, we;
        logic [W-1:0] d;
        logic         wl, wd, re, chk;
        logic         x_rvalid;
        logic [W-1:0] x_rdata;
        logic         x_rlast;
        logic [AW:0]  x_pkt;
        logic         x_full;
        logic [15:0]  x_drop;
    } vec_t;

    vec_t vt[9];

    initial begin
        //          r  we d      wl wd re chk rv rdata  rl pkt full drop
        vt[0] = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
        vt[1] = '{0, 1, 8'hA0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vt[2] = '{0, 1, 8'hA1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vt[3] = '{0, 1, 8'hA2, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0};
        vt[4] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0};
        vt[5] = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'hA0, 0, 1, 0, 0};
        vt[6] = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'hA1, 0, 1, 0, 0};
        vt[7] = '{0, 0, 8'h00, 0, 0, 1, 1, 1, 8'hA2, 1, 1, 0, 0};
        vt[8] = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0};

        reset = 1'b1; wen = 1'b0; wdata = '0; wlast = 1'b0; wdrop = 1'b0; ren = 1'b0;
        @(posedge clk);
        #1;

        // 3-word packet, rvalid two cycles after commit, then popped.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].chk) begin
                check("t_rvalid", 32'(rvalid), 32'(vt[i].x_rvalid));
                check("t_rdata", 32'(rdata), 32'(vt[i].x_rdata));
                check("t_rlast", 32'(rlast), 32'(vt[i].x_rlast));
                check("t_pkt_count", 32'(pkt_count), 32'(vt[i].x_pkt));
                check("t_full", 32'(full), 32'(vt[i].x_full));
                check("t_afull", 32'(afull), 32'(1'b0));
                check("t_drop_count", 32'(drop_count), 32'(vt[i].x_drop));
            end
            step(vt[i].r, vt[i].we, vt[i].d, vt[i].wl, vt[i].wd, vt[i].re);
            model_on = 1'b1;
        end

        // wdrop after 5 speculative words: nothing becomes visible.
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("drop_after_wdrop", 32'(drop_count), 32'd1);
        check("no_rvalid_after_wdrop", 32'(rvalid), 32'd0);
        wr(8'h21, 1'b0);
        wr(8'h22, 1'b1);
        idle(1);
        check("post_drop_rvalid", 32'(rvalid), 32'd1);
        check("post_drop_rdata", 32'(rdata), 32'h21);
        idle(3, 1'b1);
        check("post_drop_empty_pkt", 32'(pkt_count), 32'd0);

        // 20-word packet into depth 16: overflow after 16, rest ignored.
        for (int i = 0; i < 20; i++) begin
            if (i == 11) check("afull_free5", 32'(afull), 32'd0);
            if (i == 12) check("afull_free4", 32'(afull), 32'd1);
            if (i == 16) check("full_at_16", 32'(full), 32'd1);
            if (i == 17) check("full_clears", 32'(full), 32'd0);
            wr(8'h40 + 8'(i), (i == 19));
        end
        check("overflow_drop", 32'(drop_count), 32'd2);
        check("overflow_pkt", 32'(pkt_count), 32'd0);
        idle(3);
        check("overflow_no_rvalid", 32'(rvalid), 32'd0);

        // 15 committed entries, then write + pop in the same cycle (wraps).
        for (int p = 0; p < 5; p++)
            for (int w = 0; w < 3; w++)
                wr(8'h60 + 8'(p * 3 + w), (w == 2));
        idle(1);
        check("prefill_pkt", 32'(pkt_count), 32'd5);
        check("prefill_afull", 32'(afull), 32'd1);
        wr(8'h7F, 1'b1, 1'b1);
        check("wr_pop_pkt", 32'(pkt_count), 32'd6);
        check("wr_pop_full", 32'(full), 32'd0);
        idle(20, 1'b1);
        check("drain_pkt", 32'(pkt_count), 32'd0);

        // Write refused at full even while a pop happens.
        for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i), (i == 15));
        idle(1);
        check("full16", 32'(full), 32'd1);
        wr(8'hEE, 1'b1, 1'b1);
        check("full_refused_drop", 32'(drop_count), 32'd3);
        check("full_refused_pkt", 32'(pkt_count), 32'd1);
        check("full_pop_frees", 32'(full), 32'd0);
        idle(18, 1'b1);

        // Commit and last-word pop in the same cycle.
        wr(8'h81, 1'b1);
        wr(8'h82, 1'b1);
        idle(1);
        check("pre_sim_pkt", 32'(pkt_count), 32'd2);
        check("pre_sim_rlast", 32'(rlast), 32'd1);
        wr(8'h83, 1'b1, 1'b1);
        check("sim_commit_pop_pkt", 32'(pkt_count), 32'd2);
        idle(4, 1'b1);

        // Reset mid-packet with read data pending.
        wr(8'h91, 1'b1);
        idle(1);
        check("pre_reset_rvalid", 32'(rvalid), 32'd1);
        wr(8'h92, 1'b0);
        wr(8'h93, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_pkt", 32'(pkt_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(afull), 32'd0);

        // Randomized traffic with phases of slow and fast readers.
        for (int n = 0; n < 4000; n++) begin
            int ren_pct;
            logic r, we, wl, wd, re;
            ren_pct = ((n / 500) % 2 == 0) ? 15 : 70;
            r  = ($urandom_range(0, 999) == 0);
            we = ($urandom_range(0, 99) < 65);
            wl = ($urandom_range(0, 99) < 18);
            wd = ($urandom_range(0, 99) < 3);
            re = ($urandom_range(0, 99) < ren_pct);
            step(r, we, 8'($urandom), wl, wd, re);
        end
        compare_model();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
